// File: rtl/cp0_intc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cp0_intc_pkg
// Description : Shared constants for the vectored coprocessor-0 interrupt
//               controller: register numbers, Status bit positions and the
//               default handler address.
// Revision    : 1.0 - initial release
// ============================================================================
package cp0_intc_pkg;

    // Coprocessor-0 register numbers as seen by MFC0/MTC0
    localparam logic [4:0] c_reg_status  = 5'd12;
    localparam logic [4:0] c_reg_cause   = 5'd13;
    localparam logic [4:0] c_reg_epc     = 5'd14;
    localparam logic [4:0] c_reg_intmode = 5'd22;
    localparam logic [4:0] c_reg_intack  = 5'd23;
    localparam logic [4:0] c_reg_intid   = 5'd24;

    // Status register field positions
    localparam int c_status_ie     = 0;
    localparam int c_status_exl    = 1;
    localparam int c_status_im_lsb = 8;

    // Word address of the interrupt handler
    localparam logic [29:0] c_handler_pc_default = 30'h2000_0060;

endpackage
`default_nettype wire

// File: rtl/cp0_intc_irq_pending.sv
`default_nettype none
// ============================================================================
// Module      : cp0_intc_irq_pending
// Description : Per-line pending logic. Each line is either level sensitive
//               (pending follows the input) or edge sensitive (a rising edge
//               sets a sticky latch that software clears through IntAck).
// Revision    : 1.0 - initial release
// ============================================================================
module cp0_intc_irq_pending #(
    parameter int NUM_IRQ = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_IRQ-1:0] irq,
    input  logic [NUM_IRQ-1:0] mode,
    input  logic               ack_we,
    input  logic [NUM_IRQ-1:0] ack_mask,
    output logic [NUM_IRQ-1:0] pend
);

    logic [NUM_IRQ-1:0] r_irq_q;
    logic [NUM_IRQ-1:0] r_latch;
    logic [NUM_IRQ-1:0] w_set;
    logic [NUM_IRQ-1:0] w_clr;
    logic [NUM_IRQ-1:0] w_latch_next;

    // Edge detect and latch update; a new edge beats a same-cycle ack, and a
    // line in level mode keeps its latch empty so switching modes clears it
    always_comb begin
        w_set        = mode & irq & ~r_irq_q;
        w_clr        = ack_we ? ack_mask : '0;
        w_latch_next = mode & (w_set | (r_latch & ~w_clr));
        pend         = (mode & r_latch) | (~mode & irq);
    end

    // Previous-cycle irq sample and edge latches
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_irq_q <= '0;
            r_latch <= '0;
        end else begin
            r_irq_q <= irq;
            r_latch <= w_latch_next;
        end
    end

endmodule
`default_nettype wire

// File: rtl/cp0_intc.sv
`default_nettype none
// ============================================================================
// Module      : cp0_intc
// Description : Coprocessor-0 with a vectored, prioritised interrupt
//               controller. Holds Status/Cause/EPC/IntMode, exposes IntAck
//               and IntId, and requests a jump to the handler when an enabled
//               line is pending and interrupts are not masked by IE/EXL.
// Revision    : 1.0 - initial release
// ============================================================================
module cp0_intc
    import cp0_intc_pkg::*;
#(
    parameter  int                    NUM_IRQ    = 8,
    parameter  int                    PC_WIDTH   = 30,
    parameter  logic [PC_WIDTH-1:0]   HANDLER_PC = PC_WIDTH'(c_handler_pc_default),
    localparam int                    IDW        = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [31:0]         wr_data,
    input  logic [4:0]          regnum,
    input  logic                MTC0,
    input  logic                ERET,
    input  logic [PC_WIDTH-1:0] next_pc,
    input  logic [NUM_IRQ-1:0]  irq,
    output logic [31:0]         rd_data,
    output logic [PC_WIDTH-1:0] EPC,
    output logic [PC_WIDTH-1:0] handler_pc,
    output logic                TakenInterrupt,
    output logic [IDW-1:0]      irq_id
);

    logic                r_ie;
    logic                r_exl;
    logic [NUM_IRQ-1:0]  r_im;
    logic [NUM_IRQ-1:0]  r_mode;
    logic [PC_WIDTH-1:0] r_epc;

    logic [NUM_IRQ-1:0]  w_pend;
    logic [NUM_IRQ-1:0]  w_act;
    logic                w_any;
    logic                w_wr_status;
    logic                w_wr_epc;
    logic                w_wr_mode;
    logic                w_wr_ack;

    cp0_intc_irq_pending #(
        .NUM_IRQ (NUM_IRQ)
    ) u_pending (
        .clk      (clk),
        .reset    (reset),
        .irq      (irq),
        .mode     (r_mode),
        .ack_we   (w_wr_ack),
        .ack_mask (wr_data[NUM_IRQ-1:0]),
        .pend     (w_pend)
    );

    // Write decode, enable masking and take decision
    always_comb begin
        w_wr_status    = MTC0 && (regnum == c_reg_status);
        w_wr_epc       = MTC0 && (regnum == c_reg_epc);
        w_wr_mode      = MTC0 && (regnum == c_reg_intmode);
        w_wr_ack       = MTC0 && (regnum == c_reg_intack);
        w_act          = w_pend & r_im;
        w_any          = |w_act;
        TakenInterrupt = w_any && r_ie && !r_exl;
        EPC            = r_epc;
        handler_pc     = HANDLER_PC;
    end

    // Priority encoder: lowest-numbered active line wins, all ones when idle
    always_comb begin
        irq_id = '1;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (w_act[i]) begin
                irq_id = IDW'(i);
            end
        end
    end

    // MFC0 read mux
    always_comb begin
        rd_data = '0;
        case (regnum)
            c_reg_status: begin
                rd_data[c_status_ie]                    = r_ie;
                rd_data[c_status_exl]                   = r_exl;
                rd_data[c_status_im_lsb +: NUM_IRQ]     = r_im;
            end
            c_reg_cause:   rd_data[c_status_im_lsb +: NUM_IRQ] = w_pend;
            c_reg_epc:     rd_data = 32'({r_epc, 2'b00});
            c_reg_intmode: rd_data[NUM_IRQ-1:0] = r_mode;
            c_reg_intid:   rd_data = w_any ? 32'(irq_id) : '1;
            default:       rd_data = '0;
        endcase
    end

    // Register file; an interrupt take overrides the EXL/EPC fields of a
    // same-cycle MTC0, and an ERET that coincides with a take keeps the
    // original EPC so the chained handler returns to the first victim
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ie   <= 1'b0;
            r_exl  <= 1'b0;
            r_im   <= '0;
            r_mode <= '0;
            r_epc  <= '0;
        end else begin
            if (w_wr_status) begin
                r_ie  <= wr_data[c_status_ie];
                r_exl <= wr_data[c_status_exl];
                r_im  <= wr_data[c_status_im_lsb +: NUM_IRQ];
            end
            if (w_wr_epc) begin
                r_epc <= wr_data[PC_WIDTH+1:2];
            end
            if (w_wr_mode) begin
                r_mode <= wr_data[NUM_IRQ-1:0];
            end
            if (TakenInterrupt) begin
                r_exl <= 1'b1;
                if (ERET) begin
                    r_epc <= r_epc;
                end else begin
                    r_epc <= next_pc;
                end
            end else if (ERET) begin
                r_exl <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cp0_intc.sv
`default_nettype none
// ============================================================================
// Module      : tb_cp0_intc
// Description : Self-checking bench for cp0_intc (NUM_IRQ=8, PC_WIDTH=30).
//               Directed scenarios followed by randomized traffic, all checked
//               against a behavioural model of the coprocessor state.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cp0_intc;

    logic        clk;
    logic        reset;
    logic [31:0] wr_data;
    logic [4:0]  regnum;
    logic        MTC0;
    logic        ERET;
    logic [29:0] next_pc;
    logic [7:0]  irq;
    logic [31:0] rd_data;
    logic [29:0] EPC;
    logic [29:0] handler_pc;
    logic        TakenInterrupt;
    logic [2:0]  irq_id;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    // Behavioural model state
    bit        m_ie;
    bit        m_exl;
    bit [7:0]  m_im;
    bit [7:0]  m_mode;
    bit [7:0]  m_latch;
    bit [7:0]  m_irq_q;
    bit [29:0] m_epc;

    cp0_intc dut (
        .clk            (clk),
        .reset          (reset),
        .wr_data        (wr_data),
        .regnum         (regnum),
        .MTC0           (MTC0),
        .ERET           (ERET),
        .next_pc        (next_pc),
        .irq            (irq),
        .rd_data        (rd_data),
        .EPC            (EPC),
        .handler_pc     (handler_pc),
        .TakenInterrupt (TakenInterrupt),
        .irq_id         (irq_id)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic bit [7:0] m_pend_vec();
        bit [7:0] p;
        for (int i = 0; i < 8; i++) begin
            p[i] = m_mode[i] ? m_latch[i] : irq[i];
        end
        return p;
    endfunction

    function automatic int m_id();
        bit [7:0] a;
        a = m_pend_vec() & m_im;
        for (int i = 0; i < 8; i++) begin
            if (a[i]) return i;
        end
        return -1;
    endfunction

    function automatic bit m_taken();
        return (m_id() >= 0) && m_ie && !m_exl;
    endfunction

    function automatic bit [31:0] m_read(input bit [4:0] r);
        bit [31:0] v;
        int        id;
        v  = 32'd0;
        id = m_id();
        case (r)
            5'd12: begin
                v[0]    = m_ie;
                v[1]    = m_exl;
                v[15:8] = m_im;
            end
            5'd13: v[15:8] = m_pend_vec();
            5'd14: v = {m_epc, 2'b00};
            5'd22: v[7:0] = m_mode;
            5'd24: v = (id < 0) ? 32'hFFFF_FFFF : 32'(id);
            default: v = 32'd0;
        endcase
        return v;
    endfunction

    task automatic m_reset();
        m_ie = 0; m_exl = 0; m_im = 0; m_mode = 0;
        m_latch = 0; m_irq_q = 0; m_epc = 0;
    endtask

    // Advance the model by one clock edge using the inputs currently driven
    task automatic m_update();
        bit        take;
        bit [29:0] old_epc;
        take    = m_taken();
        old_epc = m_epc;
        for (int i = 0; i < 8; i++) begin
            if (!m_mode[i])                                     m_latch[i] = 0;
            else if (irq[i] && !m_irq_q[i])                     m_latch[i] = 1;
            else if (MTC0 && regnum == 5'd23 && wr_data[i])     m_latch[i] = 0;
        end
        m_irq_q = irq;
        if (MTC0) begin
            case (regnum)
                5'd12: begin
                    m_ie  = wr_data[0];
                    m_exl = wr_data[1];
                    m_im  = wr_data[15:8];
                end
                5'd14: m_epc  = wr_data[31:2];
                5'd22: m_mode = wr_data[7:0];
                default: ;
            endcase
        end
        if (take) begin
            m_exl = 1;
            m_epc = ERET ? old_epc : next_pc;
        end else if (ERET) begin
            m_exl = 0;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_model();
        int id;
        id = m_id();
        check("taken",   32'(TakenInterrupt), 32'(m_taken()));
        check("irq_id",  32'(irq_id), (id < 0) ? 32'd7 : 32'(id));
        check("rd_data", rd_data, m_read(regnum));
        check("epc",     32'(EPC), 32'(m_epc));
    endtask

    // Inputs are driven at the falling edge; check, then let one edge pass
    task automatic step();
        #1 check_model();
        @(posedge clk);
        m_update();
        @(negedge clk);
    endtask

    task automatic idle();
        MTC0 = 0; ERET = 0; wr_data = 0;
    endtask

    task automatic mtc0(input bit [4:0] r, input bit [31:0] d);
        MTC0 = 1; regnum = r; wr_data = d;
        step();
        idle();
    endtask

    // Asynchronous reset asserted between clock edges
    task automatic async_reset();
        idle();
        irq = 0;
        #2 reset = 0;
        #1 m_reset();
        check("rst_taken", 32'(TakenInterrupt), 32'd0);
        regnum = 5'd12; #0.5 check("rst_status", rd_data, 32'd0);
        regnum = 5'd13; #0.5 check("rst_cause",  rd_data, 32'd0);
        regnum = 5'd14; #0.5 check("rst_epc",    rd_data, 32'd0);
        regnum = 5'd22; #0.5 check("rst_mode",   rd_data, 32'd0);
        regnum = 5'd24; #0.5 check("rst_intid",  rd_data, 32'hFFFF_FFFF);
        @(negedge clk);
        reset = 1;
    endtask

    initial begin
        bit [4:0] regs [8];
        regs = '{5'd12, 5'd13, 5'd14, 5'd22, 5'd23, 5'd24, 5'd0, 5'd5};
        reset = 0; irq = 0; regnum = 0; next_pc = 0;
        idle();
        m_reset();
        repeat (2) @(negedge clk);
        reset = 1;
        check("handler_pc", 32'(handler_pc), 32'h2000_0060);

        // Level line 2 with IE and IM2
        mtc0(5'd12, 32'h0000_0401);
        irq = 8'h04; regnum = 5'd24; next_pc = 30'h0000_0123;
        #1 check("lvl_taken", 32'(TakenInterrupt), 32'd1);
        check("lvl_id", 32'(irq_id), 32'd2);
        step();
        regnum = 5'd12;
        #1 check("lvl_status", rd_data, 32'h0000_0403);
        check("lvl_epc", 32'(EPC), 32'h0000_0123);
        check("lvl_taken_off", 32'(TakenInterrupt), 32'd0);
        step();

        // ERET leaves EPC, pending level line retakes right after
        ERET = 1; next_pc = 30'h0000_0200;
        step();
        ERET = 0;
        #1 check("eret_epc", 32'(EPC), 32'h0000_0123);
        check("eret_status", rd_data, 32'h0000_0401);
        check("eret_retake", 32'(TakenInterrupt), 32'd1);
        step();
        check("retake_epc", 32'(EPC), 32'h0000_0200);

        // Software EPC write collides with a take: take wins
        ERET = 1;
        step();
        ERET = 0; next_pc = 30'h0000_0300;
        MTC0 = 1; regnum = 5'd14; wr_data = 32'h0040_0010;
        step();
        idle(); regnum = 5'd12;
        #1 check("coll_epc", 32'(EPC), 32'h0000_0300);
        check("coll_status", rd_data, 32'h0000_0403);
        step();

        // Priority among several lines
        mtc0(5'd12, 32'h0000_FF01);
        irq = 8'h0A; regnum = 5'd24;
        #1 check("prio_id", 32'(irq_id), 32'd1);
        regnum = 5'd13;
        #1 check("prio_cause", rd_data, 32'h0000_0A00);
        irq = 8'h08;
        #1 check("prio_id_drop", 32'(irq_id), 32'd3);
        step();

        // Edge mode on line 0: latched pulse, then acknowledged
        irq = 8'h00;
        mtc0(5'd12, 32'h0000_0101);
        mtc0(5'd22, 32'h0000_0001);
        step();
        irq = 8'h01;
        step();
        irq = 8'h00; regnum = 5'd13;
        #1 check("edge_held", rd_data, 32'h0000_0100);
        step();
        mtc0(5'd23, 32'h0000_0001);
        regnum = 5'd13;
        #1 check("edge_acked", rd_data, 32'h0000_0000);
        step();

        // Randomized traffic against the model, with one mid-run reset
        for (int c = 0; c < 600; c++) begin
            if (c == 300) begin
                async_reset();
            end
            MTC0    = ($urandom % 4) == 0;
            ERET    = ($urandom % 6) == 0;
            regnum  = regs[$urandom % 8];
            wr_data = $urandom;
            if (regnum == 5'd12 && ($urandom % 2) == 0) wr_data[1] = 1'b0;
            if (regnum == 5'd12) wr_data[0] = 1'b1;
            if (($urandom % 3) == 0) irq = 8'($urandom);
            next_pc = 30'($urandom);
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
